// File: rtl/xor_chk_pkg.sv
// Shared definitions for the XOR-checksum frame receiver.
//   state_t   : frame tracking state (IDLE, RUN, OVF)
//   len_width : bit width needed to hold a payload count of 0..max_len
package xor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVF
    } state_t;

    localparam int DEF_N       = 16;
    localparam int DEF_MAX_LEN = 64;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xor_out_reg.sv
// One-deep valid/ready register slice carrying a payload word and its last flag.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data/load_last (caller guarantees space=1)
//   load_data  : word to capture
//   load_last  : last flag to capture with the word
//   mark_last  : set the last flag on the word currently held (stalled)
//   m_valid    : held word valid
//   m_ready    : downstream accept
//   m_data     : held word
//   m_last     : held word is the final payload word of its frame
//   space      : slot empty or draining this cycle
module xor_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         mark_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         space
);

    assign space = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (mark_last && m_valid) begin
            m_last  <= 1'b1;
        end
    end

endmodule

// File: rtl/xor_frame_checker.sv
// Receive end of the XOR-checksum link. Payload words are forwarded through a
// registered valid/ready stage; the final (s_last) word is the XOR of the payload,
// is absorbed, and produces a one-cycle status pulse.
//   clk, rst           : clock, synchronous active-high reset
//   s_valid/s_ready    : upstream handshake, s_data word, s_last marks checksum word
//   m_valid/m_ready    : downstream handshake, m_data payload word, m_last end marker
//   stat_valid         : one-cycle pulse per finished frame
//   stat_ok, stat_len  : checksum match (and no overflow), payload word count
module xor_frame_checker
    import xor_chk_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [N-1:0]                  s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [N-1:0]                  m_data,
    output logic                          m_last,
    output logic                          stat_valid,
    output logic                          stat_ok,
    output logic [len_width(MAX_LEN)-1:0] stat_len
);

    localparam int LW = len_width(MAX_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    state_t        state;
    logic [N-1:0]  acc;
    logic [LW-1:0] len;

    logic accept;
    logic load_payload;
    logic mark_last;

    assign accept       = s_valid && s_ready;
    assign load_payload = accept && !s_last;
    // A checksum presented while a word is stalled downstream means that word
    // is the frame's final payload word; flag it before it leaves.
    assign mark_last    = s_valid && s_last && m_valid && !m_ready;

    xor_out_reg #(
        .W (N)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load_payload),
        .load_data (s_data),
        .load_last (1'b0),
        .mark_last (mark_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .space     (s_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            len        <= '0;
            stat_valid <= 1'b0;
            stat_ok    <= 1'b0;
            stat_len   <= '0;
        end else begin
            stat_valid <= 1'b0;
            stat_ok    <= 1'b0;
            stat_len   <= '0;
            if (accept) begin
                if (s_last) begin
                    stat_valid <= 1'b1;
                    stat_ok    <= (acc == s_data) && (state != OVF);
                    stat_len   <= len;
                    acc        <= '0;
                    len        <= '0;
                    state      <= IDLE;
                end else begin
                    acc <= acc ^ s_data;
                    if (len != LEN_MAX) begin
                        len <= len + LW'(1);
                    end
                    case (state)
                        IDLE:    state <= RUN;
                        RUN:     if (len == LEN_MAX) state <= OVF;
                        OVF:     state <= OVF;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_frame_checker.sv
module tb_xor_frame_checker;

    localparam int N       = 16;
    localparam int MAX_LEN = 4;
    localparam int LW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [N-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_data;
    logic          m_last;
    logic          stat_valid;
    logic          stat_ok;
    logic [LW-1:0] stat_len;

    int checks   = 0;
    int failures = 0;

    bit   ready_rand  = 1'b0;
    logic ready_force = 1'b1;

    // observed: {m_last, m_data} and {stat_ok, stat_len}
    logic [N:0]  obs_w[$];
    logic [LW:0] obs_s[$];
    // expected: {last_allowed, data} and {ok, len}
    logic [N:0]  exp_w[$];
    logic [LW:0] exp_s[$];
    logic [N-1:0] cur_pl[$];

    xor_frame_checker #(
        .N       (N),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .stat_valid (stat_valid),
        .stat_ok    (stat_ok),
        .stat_len   (stat_len)
    );

    always #5 clk = ~clk;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            m_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) obs_w.push_back({m_last, m_data});
            if (stat_valid) obs_s.push_back({stat_ok, stat_len});
        end
    end

    // Reference: frame result from the payload list alone.
    task automatic model_expect(input logic [N-1:0] c);
        logic [N-1:0] x;
        int n;
        x = '0;
        n = cur_pl.size();
        for (int i = 0; i < n; i++) begin
            x = x ^ cur_pl[i];
            exp_w.push_back({(i == n - 1), cur_pl[i]});
        end
        exp_s.push_back({((x == c) && (n <= MAX_LEN)), LW'((n > MAX_LEN) ? MAX_LEN : n)});
    endtask

    task automatic send_word(input logic [N-1:0] d, input logic last, output bit ok);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] c, input bit gaps, input bit hold, inout int tmo);
        bit ok;
        for (int i = 0; i < cur_pl.size(); i++) begin
            send_word(cur_pl[i], 1'b0, ok);
            if (!ok) tmo++;
            if (gaps && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        send_word(c, 1'b1, ok);
        if (!ok) tmo++;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic drain(inout int tmo);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!m_valid && obs_s.size() >= exp_s.size() && obs_w.size() >= exp_w.size()) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) tmo++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_last, m_data, stat_valid, stat_ok, stat_len} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got mv=%b ml=%b md=%h sv=%b so=%b sl=%0d expected all 0",
                     m_valid, m_last, m_data, stat_valid, stat_ok, stat_len);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready: got %b expected 1", s_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fixed_frames();
        int tmo = 0;
        ready_rand = 1'b1;
        cur_pl = '{16'haaaa, 16'h0fff};
        send_frame(16'ha555, 1'b1, 1'b0, tmo);
        cur_pl = '{16'h0f0f, 16'h3333};
        send_frame(16'h3c3d, 1'b1, 1'b0, tmo);
        cur_pl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        send_frame(16'h0001, 1'b1, 1'b0, tmo);
        cur_pl = {};
        send_frame(16'h0000, 1'b0, 1'b0, tmo);
        send_frame(16'h0001, 1'b0, 1'b0, tmo);
        exp_w = '{{1'b0, 16'haaaa}, {1'b1, 16'h0fff}, {1'b0, 16'h0f0f}, {1'b1, 16'h3333},
                  {1'b0, 16'h0001}, {1'b0, 16'h0002}, {1'b0, 16'h0003}, {1'b0, 16'h0004},
                  {1'b1, 16'h0005}};
        exp_s = '{{1'b1, 3'd2}, {1'b0, 3'd2}, {1'b0, 3'd4}, {1'b1, 3'd0}, {1'b0, 3'd0}};
        drain(tmo);
        ready_rand = 1'b0;
        checks++;
        if (tmo != 0) begin
            failures++;
            $display("FAIL fixed_timeout: got %0d timeouts expected 0", tmo);
        end
        checks++;
        if (obs_w.size() != exp_w.size() || obs_s.size() != exp_s.size()) begin
            failures++;
            $display("FAIL fixed_counts: got words=%0d stats=%0d expected words=%0d stats=%0d",
                     obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
        end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (obs_w[i][N-1:0] !== exp_w[i][N-1:0] || (obs_w[i][N] !== 1'b0 && !exp_w[i][N])) begin
                failures++;
                $display("FAIL fixed_word[%0d]: got last=%b data=%h expected data=%h last_allowed=%b",
                         i, obs_w[i][N], obs_w[i][N-1:0], exp_w[i][N-1:0], exp_w[i][N]);
            end
        end
        for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (obs_s[i] !== exp_s[i]) begin
                failures++;
                $display("FAIL fixed_stat[%0d]: got ok=%b len=%0d expected ok=%b len=%0d",
                         i, obs_s[i][LW], obs_s[i][LW-1:0], exp_s[i][LW], exp_s[i][LW-1:0]);
            end
        end
        obs_w.delete(); obs_s.delete(); exp_w.delete(); exp_s.delete();
    endtask

    task automatic test_backpressure();
        int tmo = 0;
        bit ok;
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        send_word(16'haaaa, 1'b0, ok);
        if (!ok) tmo++;
        ready_force = 1'b0;
        s_data = 16'h0fff;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 16'haaaa) begin
                failures++;
                $display("FAIL bp_stall[%0d]: got s_ready=%b m_valid=%b m_data=%h expected 0 1 aaaa",
                         i, s_ready, m_valid, m_data);
            end
        end
        ready_force = 1'b1;
        send_word(16'h0fff, 1'b0, ok);
        if (!ok) tmo++;
        ready_force = 1'b0;
        s_data = 16'ha555;
        s_last = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_last !== 1'b1 || m_data !== 16'h0fff || m_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_m_last: got m_last=%b m_data=%h m_valid=%b expected 1 0fff 1",
                     m_last, m_data, m_valid);
        end
        ready_force = 1'b1;
        send_word(16'ha555, 1'b1, ok);
        if (!ok) tmo++;
        s_valid = 1'b0;
        cur_pl = '{16'haaaa, 16'h0fff};
        model_expect(16'ha555);
        drain(tmo);
        checks++;
        if (tmo != 0 || obs_w.size() != 2 || obs_s.size() != 1) begin
            failures++;
            $display("FAIL bp_counts: got tmo=%0d words=%0d stats=%0d expected 0 2 1",
                     tmo, obs_w.size(), obs_s.size());
        end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (obs_w[i][N-1:0] !== exp_w[i][N-1:0] || (obs_w[i][N] !== 1'b0 && !exp_w[i][N])) begin
                failures++;
                $display("FAIL bp_word[%0d]: got last=%b data=%h expected data=%h",
                         i, obs_w[i][N], obs_w[i][N-1:0], exp_w[i][N-1:0]);
            end
        end
        checks++;
        if (obs_s.size() < 1 || obs_s[0] !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL bp_stat: got %b expected ok=1 len=2", (obs_s.size() > 0) ? obs_s[0] : 4'bx);
        end
        obs_w.delete(); obs_s.delete(); exp_w.delete(); exp_s.delete();
    endtask

    task automatic test_mid_reset();
        int tmo = 0;
        bit ok;
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        send_word(16'haaaa, 1'b0, ok);
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_w.delete(); obs_s.delete();
        checks++;
        if (m_valid !== 1'b0 || stat_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs: got m_valid=%b stat_valid=%b expected 0 0", m_valid, stat_valid);
        end
        cur_pl = '{16'h1234};
        send_frame(16'h1234, 1'b0, 1'b0, tmo);
        drain(tmo);
        checks++;
        if (tmo != 0 || obs_s.size() != 1 || obs_w.size() != 1) begin
            failures++;
            $display("FAIL midrst_counts: got tmo=%0d words=%0d stats=%0d expected 0 1 1",
                     tmo, obs_w.size(), obs_s.size());
        end
        checks++;
        if (obs_s.size() < 1 || obs_s[0] !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL midrst_stat: got %b expected ok=1 len=1", (obs_s.size() > 0) ? obs_s[0] : 4'bx);
        end
        checks++;
        if (obs_w.size() < 1 || obs_w[0][N-1:0] !== 16'h1234) begin
            failures++;
            $display("FAIL midrst_word: got %h expected 1234", (obs_w.size() > 0) ? obs_w[0][N-1:0] : 16'hx);
        end
        obs_w.delete(); obs_s.delete();
    endtask

    task automatic test_back_to_back();
        int tmo = 0;
        logic [N-1:0] c;
        ready_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            cur_pl = {};
            for (int i = 0; i < $urandom_range(0, 6); i++) begin
                cur_pl.push_back(N'($urandom));
            end
            c = '0;
            foreach (cur_pl[i]) c = c ^ cur_pl[i];
            if ($urandom_range(0, 1) == 0) c = N'($urandom);
            model_expect(c);
            send_frame(c, ($urandom_range(0, 3) == 0), 1'b1, tmo);
        end
        s_valid = 1'b0;
        drain(tmo);
        ready_rand = 1'b0;
        checks++;
        if (tmo != 0 || obs_w.size() != exp_w.size() || obs_s.size() != exp_s.size()) begin
            failures++;
            $display("FAIL b2b_counts: got tmo=%0d words=%0d stats=%0d expected 0 %0d %0d",
                     tmo, obs_w.size(), obs_s.size(), exp_w.size(), exp_s.size());
        end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (obs_w[i][N-1:0] !== exp_w[i][N-1:0] || (obs_w[i][N] !== 1'b0 && !exp_w[i][N])) begin
                failures++;
                $display("FAIL b2b_word[%0d]: got last=%b data=%h expected data=%h last_allowed=%b",
                         i, obs_w[i][N], obs_w[i][N-1:0], exp_w[i][N-1:0], exp_w[i][N]);
            end
        end
        for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (obs_s[i] !== exp_s[i]) begin
                failures++;
                $display("FAIL b2b_stat[%0d]: got ok=%b len=%0d expected ok=%b len=%0d",
                         i, obs_s[i][LW], obs_s[i][LW-1:0], exp_s[i][LW], exp_s[i][LW-1:0]);
            end
        end
        obs_w.delete(); obs_s.delete(); exp_w.delete(); exp_s.delete();
    endtask

    initial begin
        test_reset();
        test_fixed_frames();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
